// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN to complete MULT/MULTU in one cycle on a 64-bit multiplier.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // acc holds the 64-bit product, or the dividend/quotient in its low half.
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] mcand_q, mcand_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;

    logic        op_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [33:0] rem_sh;
    logic [33:0] div_diff;
    logic        div_ge;

    function automatic logic [31:0] magnitude(input logic is_signed, input logic signed [31:0] v);
        logic signed [31:0] n;
        n = -v;
        return (is_signed && v[31]) ? n : v;
    endfunction

    function automatic logic [31:0] neg32_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64_if(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        op_signed = ~op[0];
        mag_a     = magnitude(op_signed, a);
        mag_b     = magnitude(op_signed, b);

        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        rem_sh    = {rem_q, acc_q[31]};
        div_diff  = rem_sh - {2'b00, mcand_q};
        div_ge    = (rem_sh >= {2'b00, mcand_q});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = op_signed & (a[31] ^ b[31]);
                    neg_rem_d = op_signed & a[31];
                    div0_d    = op[1] & (b == 32'd0);
                    rem_d     = 33'd0;
                    cnt_d     = 5'd31;
                    state_d   = S_RUN;
                    if (op[1]) begin
                        acc_d   = {32'd0, mag_a};
                        mcand_d = mag_b;
                    end else begin
                        acc_d   = {32'd0, mag_b};
                        mcand_d = mag_a;
`ifdef MULDIV_FAST_MULT_EN
                        acc_d   = {32'd0, mag_a} * {32'd0, mag_b};
                        state_d = S_FIN;
`endif
                    end
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: shift in the next dividend bit, subtract if it fits.
                    rem_d        = div_ge ? div_diff[32:0] : rem_sh[32:0];
                    acc_d[31:0]  = {acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    lo_d = div0_q ? 32'hFFFF_FFFF : neg32_if(neg_res_q, acc_q[31:0]);
                    hi_d = neg32_if(neg_rem_q, rem_q[31:0]);
                end else begin
                    {hi_d, lo_d} = neg64_if(neg_res_q, acc_q);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        rem_q     <= rem_d;
        mcand_q   <= mcand_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        div0_q    <= div0_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
